// File: rtl/run_info_collector.sv
// run_info_collector: input stage of the player-action controller.
// Samples the shared 144-bit bus D under per-field strobes and checks that the
// field order is legal for the selected action. It packs one command into a
// This_run_info_t record and offers it downstream over cmd_valid/cmd_ready.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   sel_action_valid .. MP_valid  per-field strobes qualifying D
//   D[143:0]                  data bus (only the low slice of each field is used)
//   cmd_valid / cmd_ready     record handshake; cmd_info is the record
//   busy                      command being collected or held
//   proto_err                 one-cycle pulse after any protocol violation
//
// Optional: define RUN_INFO_DATE_CHECK_EN to range-check every accepted date.

package run_info_collector_pkg;

  typedef struct packed {
    logic [3:0] m;
    logic [4:0] d;
  } date_t;

  typedef struct packed {
    logic [2:0]       act;
    logic [1:0]       training_type;
    logic [1:0]       mode;
    date_t            today;
    logic [7:0]       player_no;
    logic [15:0]      m_attack;
    logic [15:0]      m_defense;
    logic [15:0]      m_hp;
    logic [3:0][15:0] mp_consumed;
  } This_run_info_t;

  typedef enum logic [1:0] {C_IDLE, C_COLLECT, C_HOLD} state_e;

  localparam logic [2:0] ACT_LOGIN     = 3'd0;
  localparam logic [2:0] ACT_LEVEL_UP  = 3'd1;
  localparam logic [2:0] ACT_BATTLE    = 3'd2;
  localparam logic [2:0] ACT_USE_SKILL = 3'd3;
  localparam logic [2:0] ACT_LAST      = 3'd4;

endpackage

module run_info_collector
  import run_info_collector_pkg::*;
#(
  parameter int unsigned GAP_LIMIT = 0,
  parameter int unsigned CNT_W     = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sel_action_valid,
  input  logic           type_valid,
  input  logic           mode_valid,
  input  logic           date_valid,
  input  logic           player_no_valid,
  input  logic           monster_valid,
  input  logic           MP_valid,
  input  logic [143:0]   D,
  output logic           cmd_valid,
  input  logic           cmd_ready,
  output This_run_info_t cmd_info,
  output logic           busy,
  output logic           proto_err
);

  localparam int unsigned S_ACT    = 0;
  localparam int unsigned S_TYPE   = 1;
  localparam int unsigned S_MODE   = 2;
  localparam int unsigned S_DATE   = 3;
  localparam int unsigned S_PLAYER = 4;
  localparam int unsigned S_MON    = 5;
  localparam int unsigned S_MP     = 6;

  state_e         r_state, w_state_nxt;
  This_run_info_t r_info, w_info_nxt;
  logic [2:0]     r_idx, w_idx_nxt;
  logic [CNT_W-1:0] r_gap, w_gap_nxt, w_gap_inc;
  logic           r_valid, w_valid_nxt;
  logic           r_busy, w_busy_nxt;
  logic           r_err, w_err;

  logic [6:0]     w_strb, w_exp;
  logic           w_any, w_multi;
  logic [2:0]     w_last;
  date_t          w_date;
  logic           w_unused_d;

  assign w_strb = {MP_valid, monster_valid, player_no_valid, date_valid,
                   mode_valid, type_valid, sel_action_valid};
  assign w_any   = |w_strb;
  assign w_multi = w_any && ((w_strb & (w_strb - 7'd1)) != 7'd0);
  assign w_date  = D[8:0];
  assign w_gap_inc = r_gap + CNT_W'(1);
  assign w_unused_d = ^D[143:16];

  // Strobe expected at position idx of the given action's field sequence.
  function automatic logic [6:0] f_exp_strb(input logic [2:0] act, input logic [2:0] idx);
    logic [6:0] s;
    s = '0;
    if (act == ACT_LEVEL_UP) begin
      case (idx)
        3'd0:    s[S_TYPE]   = 1'b1;
        3'd1:    s[S_MODE]   = 1'b1;
        3'd2:    s[S_DATE]   = 1'b1;
        3'd3:    s[S_PLAYER] = 1'b1;
        default: s = '0;
      endcase
    end else if (idx == 3'd0) begin
      s[S_DATE] = 1'b1;
    end else if (idx == 3'd1) begin
      s[S_PLAYER] = 1'b1;
    end else if (act == ACT_BATTLE) begin
      s[S_MON] = 1'b1;
    end else if (act == ACT_USE_SKILL) begin
      s[S_MP] = 1'b1;
    end
    return s;
  endfunction

  function automatic logic [2:0] f_last_idx(input logic [2:0] act);
    case (act)
      ACT_LEVEL_UP:  return 3'd3;
      ACT_BATTLE:    return 3'd4;
      ACT_USE_SKILL: return 3'd5;
      default:       return 3'd1;
    endcase
  endfunction

`ifdef RUN_INFO_DATE_CHECK_EN
  // Calendar range check without leap years (February capped at 28).
  function automatic logic f_date_ok(input date_t dt);
    logic [4:0] max_d;
    case (dt.m)
      4'd2:                                     max_d = 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:                  max_d = 5'd30;
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: max_d = 5'd31;
      default:                                  max_d = 5'd0;
    endcase
    return (dt.d != 5'd0) && (dt.d <= max_d);
  endfunction
`endif

  assign w_exp  = f_exp_strb(r_info.act, r_idx);
  assign w_last = f_last_idx(r_info.act);

  // Next-state, capture and violation logic.
  always_comb begin
    w_state_nxt = r_state;
    w_info_nxt  = r_info;
    w_idx_nxt   = r_idx;
    w_gap_nxt   = r_gap;
    w_valid_nxt = r_valid;
    w_err       = 1'b0;

    unique case (r_state)
      C_IDLE: begin
        w_valid_nxt = 1'b0;
        w_gap_nxt   = '0;
        w_idx_nxt   = '0;
        if (w_multi) begin
          w_err = 1'b1;
        end else if (sel_action_valid) begin
          if (D[2:0] > ACT_LAST) begin
            w_err = 1'b1;
          end else begin
            w_info_nxt     = '0;
            w_info_nxt.act = D[2:0];
            w_state_nxt    = C_COLLECT;
          end
        end else if (w_any) begin
          w_err = 1'b1;
        end
      end

      C_COLLECT: begin
        if (w_multi || (w_any && (w_strb != w_exp))) begin
          w_err = 1'b1;
        end else if (w_any) begin
          w_gap_nxt = '0;
          if (w_strb[S_TYPE])   w_info_nxt.training_type = D[1:0];
          if (w_strb[S_MODE])   w_info_nxt.mode          = D[1:0];
          if (w_strb[S_DATE])   w_info_nxt.today         = w_date;
          if (w_strb[S_PLAYER]) w_info_nxt.player_no     = D[7:0];
          if (w_strb[S_MON]) begin
            case (r_idx)
              3'd2:    w_info_nxt.m_attack  = D[15:0];
              3'd3:    w_info_nxt.m_defense = D[15:0];
              default: w_info_nxt.m_hp      = D[15:0];
            endcase
          end
          // MP fields occupy sequence positions 2..5.
          if (w_strb[S_MP]) w_info_nxt.mp_consumed[2'(r_idx - 3'd2)] = D[15:0];
          if (r_idx == w_last) begin
            w_state_nxt = C_HOLD;
            w_valid_nxt = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
`ifdef RUN_INFO_DATE_CHECK_EN
          if (w_strb[S_DATE] && !f_date_ok(w_date)) begin
            w_err       = 1'b1;
            w_state_nxt = C_IDLE;
            w_info_nxt  = '0;
            w_idx_nxt   = '0;
            w_valid_nxt = 1'b0;
          end
`endif
        end else if (GAP_LIMIT != 0) begin
          // Watchdog: abandon a command that stalls too long between strobes.
          if (w_gap_inc == CNT_W'(GAP_LIMIT)) begin
            w_err       = 1'b1;
            w_state_nxt = C_IDLE;
            w_info_nxt  = '0;
            w_idx_nxt   = '0;
            w_gap_nxt   = '0;
          end else begin
            w_gap_nxt = w_gap_inc;
          end
        end
      end

      C_HOLD: begin
        if (w_any) w_err = 1'b1;
        if (cmd_ready) begin
          w_state_nxt = C_IDLE;
          w_valid_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt = C_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != C_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= C_IDLE;
      r_info  <= '0;
      r_idx   <= '0;
      r_gap   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_info  <= w_info_nxt;
      r_idx   <= w_idx_nxt;
      r_gap   <= w_gap_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= w_err;
    end
  end

  assign cmd_valid = r_valid;
  assign cmd_info  = r_info;
  assign busy      = r_busy;
  assign proto_err = r_err;

endmodule

// File: doc/run_info_collector.md
Name: run_info_collector

Overview:
- Upstream input stage of the player-action controller.
- Samples the shared 144-bit input bus `D` under the per-field valid strobes. Checks that the field sequence is legal for the selected action.
- Packs one complete command into a `This_run_info_t` record, then hands it to the action FSM over a valid/ready handshake.
- Decouples the strobe-level input protocol from the DRAM/compute datapath.

Parameters:
- GAP_LIMIT, 0, max idle cycles allowed between consecutive strobes of one command; 0 disables the watchdog.
- CNT_W, 8, width of the gap counter; GAP_LIMIT must be < 2^CNT_W.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sel_action_valid  in  1  `D.d_act[0]` holds the Action
- type_valid  in  1  `D.d_type[0]` holds the Training_Type
- mode_valid  in  1  `D.d_mode[0]` holds the Mode
- date_valid  in  1  `D.d_date[0]` holds today's Date
- player_no_valid  in  1  `D.d_player_no[0]` holds the Player_No
- monster_valid  in  1  `D.d_attribute[0]` holds one monster Attribute
- MP_valid  in  1  `D.d_attribute[0]` holds one MP_consumed Attribute
- D  in  144  Data union bus
- cmd_valid  out  1  `cmd_info` is complete and stable
- cmd_ready  in  1  downstream accepts `cmd_info`
- cmd_info  out  136  `This_run_info_t` record
- busy  out  1  a command is being collected or held
- proto_err  out  1  one-cycle pulse on any protocol violation

Behaviour:
- Reset values: `cmd_valid`=0, `cmd_info`=0, `busy`=0, `proto_err`=0, FSM=C_IDLE, field index=0, gap counter=0. A reset asserted mid-command or mid-hold discards all partial or held data.
- All outputs are registered. Each strobe is captured on the clock edge where it is high.
- States and transitions:
  - C_IDLE: on `sel_action_valid`, clear `cmd_info`, store `act`, go to C_COLLECT with the field index at 0.
  - C_COLLECT: each legal strobe stores its field and advances the index. After the last field, go to C_HOLD with `cmd_valid`=1 on the next cycle.
  - C_HOLD: `cmd_info` is held constant. `cmd_valid` stays 1 until a cycle where `cmd_ready`=1; on that edge go to C_IDLE and `cmd_valid`=0.
- Required field sequence per action:
  - Login: date, player_no
  - Level_Up: type, mode, date, player_no
  - Battle: date, player_no, monster x3 (in order: `m_attack`, `m_defense`, `m_HP`)
  - Use_Skill: date, player_no, MP x4 (in order: `MP_consumed[0]`..`[3]`)
  - Check_Inactive: date, player_no
- Fields not used by the action remain 0.
- Field extraction uses the low slice of `D` only: act[2:0], type[1:0], mode[1:0], date[8:0], player[7:0], attribute[15:0]. Upper bits of `D` are ignored.
- `busy` = 1 in C_COLLECT and C_HOLD.
- Violations: each pulses `proto_err` for exactly one cycle on the following cycle.
  - Action code 5..7 in C_IDLE: nothing is stored, FSM stays in C_IDLE.
  - A strobe other than `sel_action_valid` in C_IDLE: ignored.
  - More than one strobe high in the same cycle (any state): all strobes in that cycle are ignored, FSM unchanged.
  - An unexpected strobe in C_COLLECT, including `sel_action_valid`: ignored, FSM and index unchanged. A new action cannot restart an open command.
  - Any strobe in C_HOLD: ignored, hold continues.
- Gap watchdog (GAP_LIMIT>0):
  - Counter resets on every accepted strobe and increments on each strobe-free C_COLLECT cycle.
  - When it reaches GAP_LIMIT: pulse `proto_err`, drop the partial command, go to C_IDLE.
  - Inactive in C_IDLE and C_HOLD.
- When `cmd_ready` is already high as C_HOLD is entered, `cmd_valid` is high for exactly one cycle. `cmd_ready` outside C_HOLD is ignored.
- Throughput: a new `sel_action_valid` is accepted at the earliest in the cycle after the handshake completes.

Optional Feature:
- RUN_INFO_DATE_CHECK_EN
- Defined: every accepted date is range-checked.
  - Legal ranges: M in 1..12; D in 1..31 for months 1,3,5,7,8,10,12; 1..30 for 4,6,9,11; 1..28 for 2.
  - An illegal date pulses `proto_err`, drops the command and returns to C_IDLE.
- Undefined: dates are stored unchecked. No extra logic is synthesised.

Test Plan:
- Login (act=0), date {M=3,D=15}, player 0x2A -> `cmd_valid` 1 cycle after the player strobe; cmd_info act=0, today={3,15}, player=0x2A, all other fields 0.
- Battle (act=2), date {1,1}, player 7, monster strobes 0x0100/0x0080/0x0300 with `cmd_ready` low for 5 cycles -> `cmd_valid` held 5+ cycles, cmd_info stable, m_attack=0x0100, m_defense=0x0080, m_HP=0x0300; drops on the first ready-high edge.
- Use_Skill (act=3), MP strobes 10,20,30,40 -> MP_consumed[0..3]=10,20,30,40.
- Level_Up (act=1), `date_valid` strobed before `type_valid` -> `proto_err` pulse, FSM still waits for type; then type=B, mode=Hard, date, player completes normally.
- `sel_action_valid` with act=6 -> `proto_err` pulse, `busy` stays 0. `type_valid` and `mode_valid` together in C_COLLECT -> `proto_err`, both ignored.
- GAP_LIMIT=4, Login with date then 4 idle cycles -> `proto_err`, `busy`=0, no `cmd_valid`. Reset asserted during C_HOLD -> `cmd_valid`=0 and `cmd_info`=0 on the next cycle.
